hv_stage_sequencer: RTL

Sequences RPSC tube supplies on and off in order: FAN, CA, G1, AN, G2, DR_AMP (stages 0..5). Each stage enable is gated by its ON_PERM, confirmed by its ACT feedback, and followed by a dwell before the next stage is enabled. Any trip, lost permissive or lost feedback drops all HV stages at once and runs the fan down. The block sits between the registered input stage and the relay/lamp driver logic.

---
 rtl/hv_stage_sequencer_if.sv | 18 +
 rtl/hv_stage_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/hv_stage_sequencer_if.sv
// hv_stage_sequencer_if: command, permissive/feedback and status bundle for the HV stage sequencer
// Signals: i_start, i_stop, i_trip, i_fault_clear, i_perm[5:0], i_act[5:0] toward the sequencer;
//   o_stage_on[5:0], o_hv_ready, o_busy, o_fault, o_fault_code[2:0], o_fault_stage[2:0] from it.
// Modports: master drives the requests/feedback, slave is the sequencer.
interface hv_stage_sequencer_if;
  logic i_start, i_stop, i_trip, i_fault_clear;
  logic [5:0] i_perm, i_act, o_stage_on;
  logic o_hv_ready, o_busy, o_fault;
  logic [2:0] o_fault_code, o_fault_stage;
  modport master (
    output i_start, i_stop, i_trip, i_fault_clear, i_perm, i_act,
    input  o_stage_on, o_hv_ready, o_busy, o_fault, o_fault_code, o_fault_stage
  );
  modport slave (
    input  i_start, i_stop, i_trip, i_fault_clear, i_perm, i_act,
    output o_stage_on, o_hv_ready, o_busy, o_fault, o_fault_code, o_fault_stage
  );
endinterface

// File: rtl/hv_stage_sequencer.sv
// hv_stage_sequencer: ramps RPSC supply stages FAN..DR_AMP up/down in order with ACT confirmation, dwell and latched faults
// Ports: clk, reset (asynchronous, active-high), bus (slave side of hv_stage_sequencer_if).
// Option: define HVSEQ_CA_WARMUP_EN to give the cathode stage (1) a CA_WARMUP dwell instead of STEP_DELAY.
module hv_stage_sequencer #(
  parameter int STEP_DELAY  = 1000,
  parameter int ACK_TIMEOUT = 5000,
  parameter int FAN_RUNDOWN = 60000,
  parameter int CA_WARMUP   = 30000
) (
  input logic clk,
  input logic reset,
  hv_stage_sequencer_if.slave bus
);
  localparam int M0 = STEP_DELAY > ACK_TIMEOUT ? STEP_DELAY : ACK_TIMEOUT;
  localparam int M1 = M0 > FAN_RUNDOWN ? M0 : FAN_RUNDOWN;
  localparam int CW = $clog2(M1 > CA_WARMUP ? M1 : CA_WARMUP) + 1;
`ifdef HVSEQ_CA_WARMUP_EN
  localparam int CA_DWELL = CA_WARMUP;
`else
  localparam int CA_DWELL = STEP_DELAY;
`endif
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DELAY - 1);
  localparam logic [CW-1:0] CA_LAST   = CW'(CA_DWELL - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] FAN_LAST  = CW'(FAN_RUNDOWN - 1);
  typedef enum logic [2:0] {IDLE, RAMP, DWELL, RUN, DOWN, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] k, k_n, kp, code_n, fstage_n;
  logic [5:0] stage_n, lt_k, perm_lost, act_lost, shed;
  logic mon, flt, fault_n, busy_n;
  function automatic logic [2:0] lowest(input logic [5:0] v);
    lowest = '0;
    for (int i = 5; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction
  always_comb begin
    kp = k + 3'd1;
    lt_k = 6'((7'd1 << k) - 7'd1);
    mon = state inside {RAMP, DWELL, RUN};
    perm_lost = mon ? bus.o_stage_on & ~bus.i_perm : '0;
    // stage k counts as confirmed once its ACT has been seen (DWELL/RUN), not while still ramping
    act_lost = mon ? (state == RAMP ? lt_k : {lt_k[4:0], 1'b1}) & ~bus.i_act : '0;
    // enabled stages are always a contiguous run from bit 0, so shifting drops the top HV stage and the fan is kept
    shed = (bus.o_stage_on >> 1) | {5'b0, bus.o_stage_on[0]};
    state_n = state;
    cnt_n = &cnt ? cnt : cnt + CW'(1);
    k_n = k;
    stage_n = bus.o_stage_on;
    fault_n = bus.o_fault;
    code_n = bus.o_fault_code;
    fstage_n = bus.o_fault_stage;
    flt = 1'b0;
    if (bus.i_trip && state != FAULT) begin
      flt = 1'b1; code_n = 3'd1; fstage_n = 3'd7;
    end else if (|perm_lost) begin
      flt = 1'b1; code_n = 3'd3; fstage_n = lowest(perm_lost);
    end else if (|act_lost) begin
      flt = 1'b1; code_n = 3'd4; fstage_n = lowest(act_lost);
    end else if (state == RAMP && !bus.i_act[k] && cnt == ACK_LAST) begin
      flt = 1'b1; code_n = 3'd2; fstage_n = k;
    end else if (mon && bus.i_stop) begin
      state_n = DOWN; stage_n = shed; cnt_n = '0;
    end else begin
      case (state)
        IDLE: if (bus.i_start && !bus.i_stop && !bus.o_fault && bus.i_perm[0]) begin
          state_n = RAMP; k_n = '0; stage_n = 6'h01; cnt_n = '0;
        end
        RAMP: if (bus.i_act[k]) begin
          state_n = DWELL; cnt_n = '0;
        end
        DWELL: if (cnt == (k == 3'd1 ? CA_LAST : STEP_LAST)) begin
          if (k == 3'd5) state_n = RUN;
          else if (bus.i_perm[kp]) begin
            state_n = RAMP; k_n = kp; stage_n = {bus.o_stage_on[4:0], 1'b1}; cnt_n = '0;
          end else cnt_n = cnt;
        end
        DOWN: if (|bus.o_stage_on[5:1]) begin
          if (cnt == STEP_LAST) begin
            stage_n = shed; cnt_n = '0;
          end
        end else if (cnt == FAN_LAST) begin
          stage_n = '0; state_n = IDLE;
        end
        FAULT: if (bus.i_fault_clear && bus.o_stage_on == '0) begin
          state_n = IDLE; fault_n = 1'b0; code_n = '0; fstage_n = '0;
        end else if (cnt == FAN_LAST) stage_n[0] = 1'b0;
        default: ;
      endcase
    end
    if (flt) begin
      state_n = FAULT; fault_n = 1'b1; stage_n = {5'b0, bus.o_stage_on[0]}; cnt_n = '0;
    end
    busy_n = state_n inside {RAMP, DWELL, DOWN} || (state_n == FAULT && stage_n[0]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      bus.o_stage_on <= '0;
      bus.o_hv_ready <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_fault <= 1'b0;
      bus.o_fault_code <= '0;
      bus.o_fault_stage <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      bus.o_stage_on <= stage_n;
      bus.o_hv_ready <= state_n == RUN;
      bus.o_busy <= busy_n;
      bus.o_fault <= fault_n;
      bus.o_fault_code <= code_n;
      bus.o_fault_stage <= fstage_n;
    end
endmodule
